// File: rtl/usb_ep_tx_sched.sv
// ---------------------------------------------------------------------------
// usb_ep_tx_sched
//
// Connects NUM_EP byte producers to the single IN-endpoint TX port of the USB
// device controller. Each producer writes into its own FIFO. The block answers
// the controller for the endpoint it is addressing (cork, length, head byte)
// and hands out one packet of up to MAX_PKT bytes for each txact burst.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   ep_wr_en    per-endpoint byte write strobe
//   ep_wr_data  per-endpoint write byte, slice i = [8i+7:8i]
//   ep_full     FIFO i holds FIFO_DEPTH bytes
//   ep_level    FIFO i occupancy, (AW+1) bits per endpoint
//   endpt       endpoint number the controller is addressing
//   txact       controller IN transaction active
//   txpop       controller consumes txdat this cycle
//   txval       txdat valid while a packet is being sent
//   txcork      no data for the addressed endpoint (controller NAKs)
//   txdat       head byte of the selected FIFO
//   txdat_len   number of bytes offered for this packet
//   err_pop     one-cycle pulse when txpop arrives with nothing to send
// ---------------------------------------------------------------------------
module usb_ep_tx_sched #(
    parameter int NUM_EP     = 2,
    parameter int EP_BASE    = 1,
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_PKT    = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_EP-1:0]                        ep_wr_en,
    input  logic [NUM_EP*8-1:0]                      ep_wr_data,
    output logic [NUM_EP-1:0]                        ep_full,
    output logic [NUM_EP*($clog2(FIFO_DEPTH)+1)-1:0] ep_level,
    input  logic [3:0]                               endpt,
    input  logic                                     txact,
    input  logic                                     txpop,
    output logic                                     txval,
    output logic                                     txcork,
    output logic [7:0]                               txdat,
    output logic [11:0]                              txdat_len,
    output logic                                     err_pop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;
    typedef logic [IW-1:0] idx_t;

    localparam logic [4:0] EP_LO   = 5'(EP_BASE);
    localparam logic [4:0] EP_HI   = 5'(EP_BASE + NUM_EP);
    localparam lvl_t       DEPTH_L = lvl_t'(FIFO_DEPTH);
    localparam logic [11:0] MAX_L  = 12'(MAX_PKT);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DRAIN
    } state_t;

    logic [7:0]  mem_q   [NUM_EP][FIFO_DEPTH];
    ptr_t        wrPtr_q [NUM_EP];
    ptr_t        rdPtr_q [NUM_EP];
    lvl_t        level_q [NUM_EP];

    state_t      state_q;
    logic        txactPrev_q;
    idx_t        sel_q;
    logic [11:0] rem_q;
    logic        txval_q;
    logic        txcork_q;
    logic [7:0]  txdat_q;
    logic [11:0] txdat_len_q;
    logic        err_pop_q;

    logic [4:0]        endptExt;
    logic              mapped;
    idx_t              idx;
    lvl_t              levelIdx;
    logic              hasData;
    logic [7:0]        headIdx;
    logic [11:0]       lenIdx;
    logic              popEn;
    logic [NUM_EP-1:0] push;
    logic [NUM_EP-1:0] pop;
    ptr_t              rdNextSel;

    // Decode the addressed endpoint, look up its FIFO, and work out which
    // FIFOs push and pop this cycle. Pops only happen while a packet still
    // has bytes outstanding; a write into a full FIFO is simply ignored.
    always_comb begin
        endptExt  = {1'b0, endpt};
        mapped    = (endptExt >= EP_LO) && (endptExt < EP_HI);
        idx       = idx_t'(endptExt - EP_LO);
        levelIdx  = level_q[idx];
        hasData   = mapped && (levelIdx != '0);
        headIdx   = mem_q[idx][rdPtr_q[idx]];
        lenIdx    = (12'(levelIdx) > MAX_L) ? MAX_L : 12'(levelIdx);
        popEn     = (state_q == SEND) && txpop && (rem_q != 12'd0);
        rdNextSel = rdPtr_q[sel_q] + ptr_t'(popEn);
        push      = '0;
        pop       = '0;
        ep_full   = '0;
        ep_level  = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            push[i]    = ep_wr_en[i] && (level_q[i] != DEPTH_L);
            pop[i]     = popEn && (sel_q == idx_t'(i));
            ep_full[i] = (level_q[i] == DEPTH_L);
            ep_level[i*(AW+1) +: (AW+1)] = level_q[i];
        end
    end

    // FIFO storage has no reset: after reset the pointers and levels say
    // every FIFO is empty, so stale contents can never be read out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EP; i++) begin
            if (push[i]) begin
                mem_q[i][wrPtr_q[i]] <= ep_wr_data[i*8 +: 8];
            end
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally at
    // FIFO_DEPTH; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_EP; i++) begin
                wrPtr_q[i] <= '0;
                rdPtr_q[i] <= '0;
                level_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (push[i]) begin
                    wrPtr_q[i] <= wrPtr_q[i] + ptr_t'(1);
                end
                if (pop[i]) begin
                    rdPtr_q[i] <= rdPtr_q[i] + ptr_t'(1);
                end
                level_q[i] <= level_q[i] + lvl_t'(push[i]) - lvl_t'(pop[i]);
            end
        end
    end

    // Packet sequencer. While idle the controller-facing outputs follow the
    // addressed endpoint with one cycle of latency. A rising edge of txact on
    // an endpoint with data freezes cork/length and latches the FIFO and byte
    // count; the packet ends when all bytes are popped (then waits for txact
    // to drop) or early when the host drops txact, keeping unpopped bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            txactPrev_q <= 1'b0;
            sel_q       <= '0;
            rem_q       <= '0;
            txval_q     <= 1'b0;
            txcork_q    <= 1'b1;
            txdat_q     <= '0;
            txdat_len_q <= '0;
            err_pop_q   <= 1'b0;
        end else begin
            txactPrev_q <= txact;
            err_pop_q   <= txpop && !popEn;
            case (state_q)
                IDLE: begin
                    txval_q     <= 1'b0;
                    txcork_q    <= !hasData;
                    txdat_len_q <= mapped ? lenIdx : 12'd0;
                    txdat_q     <= hasData ? headIdx : 8'd0;
                    if (txact && !txactPrev_q && hasData) begin
                        state_q <= SEND;
                        sel_q   <= idx;
                        rem_q   <= lenIdx;
                        txval_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (popEn) begin
                        rem_q   <= rem_q - 12'd1;
                        txdat_q <= mem_q[sel_q][rdNextSel];
                    end
                    if (!txact) begin
                        state_q <= IDLE;
                        txval_q <= 1'b0;
                    end else if (popEn && (rem_q == 12'd1)) begin
                        state_q <= DRAIN;
                        txval_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    txval_q <= 1'b0;
                    if (!txact) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign txval     = txval_q;
    assign txcork    = txcork_q;
    assign txdat     = txdat_q;
    assign txdat_len = txdat_len_q;
    assign err_pop   = err_pop_q;

endmodule

// File: tb/tb_usb_ep_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_usb_ep_tx_sched
//
// Directed bench for usb_ep_tx_sched with the default parameters
// (2 endpoints mapped to USB endpoints 1 and 2, 64-byte FIFOs, 64-byte
// packets). A table of single-cycle vectors covers the basic packet and the
// unmapped / empty / stray-pop cases; hand-written sequences backed by
// per-endpoint byte queues cover long packets, full FIFOs, host abort and
// reset in the middle of a packet.
// ---------------------------------------------------------------------------
module tb_usb_ep_tx_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ep_wr_en;
    logic [15:0] ep_wr_data;
    logic [1:0]  ep_full;
    logic [13:0] ep_level;
    logic [3:0]  endpt;
    logic        txact;
    logic        txpop;
    logic        txval;
    logic        txcork;
    logic [7:0]  txdat;
    logic [11:0] txdat_len;
    logic        err_pop;

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    typedef struct {
        logic [1:0]  wrEn;
        logic [7:0]  wrData;
        logic [3:0]  endpt;
        logic        txact;
        logic        txpop;
        logic        expVal;
        logic        expCork;
        logic [7:0]  expDat;
        logic        chkDat;
        logic [11:0] expLen;
        logic        expErr;
        logic [6:0]  expLvl0;
        logic [6:0]  expLvl1;
    } vec_t;

    vec_t vecs[$];

    usb_ep_tx_sched #(
        .NUM_EP    (2),
        .EP_BASE   (1),
        .FIFO_DEPTH(64),
        .MAX_PKT   (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ep_wr_en  (ep_wr_en),
        .ep_wr_data(ep_wr_data),
        .ep_full   (ep_full),
        .ep_level  (ep_level),
        .endpt     (endpt),
        .txact     (txact),
        .txpop     (txpop),
        .txval     (txval),
        .txcork    (txcork),
        .txdat     (txdat),
        .txdat_len (txdat_len),
        .err_pop   (err_pop)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends with a visible failure.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [1:0] wrEn, input logic [7:0] wrData,
                                input logic [3:0] ep, input logic act, input logic pp,
                                input logic eVal, input logic eCork, input logic [7:0] eDat,
                                input logic cDat, input logic [11:0] eLen, input logic eErr,
                                input logic [6:0] eL0, input logic [6:0] eL1);
        vec_t v;
        v.wrEn = wrEn;   v.wrData = wrData; v.endpt = ep;     v.txact = act;
        v.txpop = pp;    v.expVal = eVal;   v.expCork = eCork; v.expDat = eDat;
        v.chkDat = cDat; v.expLen = eLen;   v.expErr = eErr;
        v.expLvl0 = eL0; v.expLvl1 = eL1;
        return v;
    endfunction

    function automatic logic [6:0] lvl(input int ep);
        return ep_level[ep*7 +: 7];
    endfunction

    function automatic int mSize(input int ep);
        return (ep == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] mFront(input int ep);
        return (ep == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void mPop(input int ep);
        if (ep == 0) void'(q0.pop_front());
        else         void'(q1.pop_front());
    endfunction

    function automatic void mPush(input int ep, input logic [7:0] d);
        if (ep == 0) q0.push_back(d);
        else         q1.push_back(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one table vector and let one rising edge pass.
    task automatic applyStimulus(input vec_t v);
        ep_wr_en   = v.wrEn;
        ep_wr_data = {v.wrData, v.wrData};
        endpt      = v.endpt;
        txact      = v.txact;
        txpop      = v.txpop;
        tick();
    endtask

    // Write one byte into FIFO ep, mirroring the accept/drop in the queue model.
    task automatic writeByte(input int ep, input logic [7:0] d);
        ep_wr_en   = 2'b01 << ep;
        ep_wr_data = {d, d};
        tick();
        if (mSize(ep) < 64) mPush(ep, d);
        ep_wr_en = 2'b00;
    endtask

    // Run one packet on FIFO ep. abortAt >= 0 drops txact after that many
    // pops. pushCnt bytes (pushBase, pushBase+1, ...) are written into the
    // same FIFO alongside pops 1..pushCnt.
    task automatic runPacket(input int ep, input int abortAt, input int pushCnt, input int pushBase);
        int n;
        logic doPush;
        logic wasFull;
        logic [7:0] d;
        endpt = 4'(ep + 1);
        txact = 1'b0;
        txpop = 1'b0;
        tick();
        tick();
        n = (mSize(ep) > 64) ? 64 : mSize(ep);
        checkOutput("idle_len", txdat_len, n);
        checkOutput("idle_cork", txcork, (n == 0));
        if (n == 0) return;
        checkOutput("idle_dat", txdat, mFront(ep));
        txact = 1'b1;
        tick();
        checkOutput("send_val", txval, 1);
        checkOutput("send_len", txdat_len, n);
        for (int k = 0; k < n; k++) begin
            if (k == abortAt) break;
            checkOutput("pkt_dat", txdat, mFront(ep));
            checkOutput("pkt_val", txval, 1);
            txpop   = 1'b1;
            doPush  = (k >= 1) && (k < 1 + pushCnt);
            d       = 8'(pushBase + k - 1);
            wasFull = (mSize(ep) == 64);
            if (doPush) begin
                ep_wr_en   = 2'b01 << ep;
                ep_wr_data = {d, d};
            end
            tick();
            ep_wr_en = 2'b00;
            mPop(ep);
            if (doPush && !wasFull) mPush(ep, d);
            checkOutput("pkt_lvl", lvl(ep), mSize(ep));
        end
        txpop = 1'b0;
        if (abortAt >= 0 && abortAt < n) begin
            txact = 1'b0;
            tick();
            checkOutput("abort_val", txval, 0);
        end else begin
            checkOutput("drain_val", txval, 0);
            checkOutput("drain_len", txdat_len, n);
            txact = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ep_wr_en   = 2'b00;
        ep_wr_data = 16'h0;
        endpt      = 4'd0;
        txact      = 1'b0;
        txpop      = 1'b0;

        // Basic five-byte packet on EP1 followed by a stray pop in DRAIN.
        vecs.push_back(mk(2'b01, 8'h10, 4'd1, 0, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd1, 7'd0));
        vecs.push_back(mk(2'b01, 8'h11, 4'd1, 0, 0, 0, 0, 8'h10, 1, 12'd1, 0, 7'd2, 7'd0));
        vecs.push_back(mk(2'b01, 8'h12, 4'd1, 0, 0, 0, 0, 8'h10, 1, 12'd2, 0, 7'd3, 7'd0));
        vecs.push_back(mk(2'b01, 8'h13, 4'd1, 0, 0, 0, 0, 8'h10, 1, 12'd3, 0, 7'd4, 7'd0));
        vecs.push_back(mk(2'b01, 8'h14, 4'd1, 0, 0, 0, 0, 8'h10, 1, 12'd4, 0, 7'd5, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 0, 0, 0, 0, 8'h10, 1, 12'd5, 0, 7'd5, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 0, 1, 0, 8'h10, 1, 12'd5, 0, 7'd5, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 1, 0, 8'h11, 1, 12'd5, 0, 7'd4, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 1, 0, 8'h12, 1, 12'd5, 0, 7'd3, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 1, 0, 8'h13, 1, 12'd5, 0, 7'd2, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 1, 0, 8'h14, 1, 12'd5, 0, 7'd1, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 0, 0, 8'h00, 0, 12'd5, 0, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 0, 0, 8'h00, 0, 12'd5, 1, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 0, 0, 0, 0, 8'h00, 0, 12'd5, 0, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 0, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd0, 7'd0));
        // Unmapped endpoint 5, empty EP1, endpoint 0, stray pops while idle.
        vecs.push_back(mk(2'b00, 8'h00, 4'd5, 0, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd5, 1, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd5, 1, 1, 0, 1, 8'h00, 1, 12'd0, 1, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd5, 0, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd1, 1, 1, 0, 1, 8'h00, 1, 12'd0, 1, 7'd0, 7'd0));
        vecs.push_back(mk(2'b00, 8'h00, 4'd0, 0, 0, 0, 1, 8'h00, 1, 12'd0, 0, 7'd0, 7'd0));

        // Reset values.
        #12;
        checkOutput("rst_txval", txval, 0);
        checkOutput("rst_txcork", txcork, 1);
        checkOutput("rst_txdat", txdat, 0);
        checkOutput("rst_len", txdat_len, 0);
        checkOutput("rst_full", ep_full, 0);
        checkOutput("rst_level", ep_level, 0);
        checkOutput("rst_err", err_pop, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_val", i), txval, vecs[i].expVal);
            checkOutput($sformatf("v%0d_cork", i), txcork, vecs[i].expCork);
            if (vecs[i].chkDat) checkOutput($sformatf("v%0d_dat", i), txdat, vecs[i].expDat);
            checkOutput($sformatf("v%0d_len", i), txdat_len, vecs[i].expLen);
            checkOutput($sformatf("v%0d_err", i), err_pop, vecs[i].expErr);
            checkOutput($sformatf("v%0d_lvl0", i), lvl(0), vecs[i].expLvl0);
            checkOutput($sformatf("v%0d_lvl1", i), lvl(1), vecs[i].expLvl1);
        end
        ep_wr_en = 2'b00;
        txact    = 1'b0;
        txpop    = 1'b0;

        // Fill EP1, overflow write dropped, then push alongside pops.
        for (int i = 0; i < 64; i++) writeByte(0, 8'(8'h80 + i));
        checkOutput("fill_full", ep_full, 2'b01);
        checkOutput("fill_lvl", lvl(0), 64);
        writeByte(0, 8'hEE);
        checkOutput("ovf_lvl", lvl(0), 64);
        checkOutput("ovf_full", ep_full[0], 1);
        runPacket(0, -1, 5, 8'hC0);
        checkOutput("cc_lvl", lvl(0), 5);
        runPacket(0, -1, 0, 0);
        checkOutput("cc_empty", lvl(0), 0);

        // 100 bytes through EP2: 64 up front, 36 more during the first packet.
        for (int i = 0; i < 64; i++) writeByte(1, 8'(i));
        runPacket(1, -1, 36, 64);
        checkOutput("big_rest", lvl(1), 36);
        runPacket(1, -1, 0, 0);
        checkOutput("big_empty", lvl(1), 0);

        // Host abort after two of five pops.
        for (int i = 0; i < 5; i++) writeByte(0, 8'(8'h50 + i));
        runPacket(0, 2, 0, 0);
        checkOutput("abort_lvl", lvl(0), 3);
        runPacket(0, -1, 0, 0);
        checkOutput("abort_empty", lvl(0), 0);

        // Reset in the middle of a packet on EP2.
        for (int i = 0; i < 3; i++) writeByte(1, 8'h77);
        endpt = 4'd2;
        tick();
        txact = 1'b1;
        tick();
        txpop = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_txval", txval, 0);
        checkOutput("mrst_cork", txcork, 1);
        checkOutput("mrst_len", txdat_len, 0);
        checkOutput("mrst_level", ep_level, 0);
        q0.delete();
        q1.delete();
        txact = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checkOutput("post_lvl1", lvl(1), 0);
        checkOutput("post_val", txval, 0);
        checkOutput("post_err", err_pop, 1);
        txpop = 1'b0;
        tick();
        checkOutput("post_err_clr", err_pop, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
